// File: rtl/tcdm_bank_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_bank_adapter_if
// Description : Request/response/SRAM bundle of one TCDM bank adapter.
//               Signal suffixes are relative to the adapter (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface tcdm_bank_adapter_if #(
  parameter int AddrMemWidth = 12,
  parameter int DataWidth    = 32,
  parameter int BeWidth      = DataWidth / 8,
  parameter int NumInLog2    = 5
);
  // interconnect request stream
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [NumInLog2-1:0]    req_ini_addr_i;
  logic [AddrMemWidth-1:0] req_tgt_addr_i;
  logic                    req_wen_i;
  logic [DataWidth-1:0]    req_wdata_i;
  logic [BeWidth-1:0]      req_be_i;
  // interconnect response stream
  logic                    resp_valid_o;
  logic                    resp_ready_i;
  logic [NumInLog2-1:0]    resp_ini_addr_o;
  logic [DataWidth-1:0]    resp_rdata_o;
  // SRAM bank port
  logic                    mem_req_o;
  logic [AddrMemWidth-1:0] mem_addr_o;
  logic                    mem_wen_o;
  logic [DataWidth-1:0]    mem_wdata_o;
  logic [BeWidth-1:0]      mem_be_o;
  logic [DataWidth-1:0]    mem_rdata_i;

  // adapter side
  modport slave (
    input  req_valid_i, req_ini_addr_i, req_tgt_addr_i, req_wen_i, req_wdata_i, req_be_i,
    output req_ready_o,
    output resp_valid_o, resp_ini_addr_o, resp_rdata_o,
    input  resp_ready_i,
    output mem_req_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_be_o,
    input  mem_rdata_i
  );

  // interconnect + SRAM side
  modport master (
    output req_valid_i, req_ini_addr_i, req_tgt_addr_i, req_wen_i, req_wdata_i, req_be_i,
    input  req_ready_o,
    input  resp_valid_o, resp_ini_addr_o, resp_rdata_o,
    output resp_ready_i,
    input  mem_req_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_be_o,
    output mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/tcdm_bank_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_bank_adapter
// Description : Converts a valid/ready request stream into fixed-latency SRAM
//               accesses and returns read data on a back-pressured response
//               stream. A credit counter reserves a FIFO slot for every read
//               in flight, so SRAM data is never dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_bank_adapter #(
  parameter int AddrMemWidth  = 12,
  parameter int DataWidth     = 32,
  parameter int BeWidth       = DataWidth / 8,
  parameter int NumInLog2     = 5,
  parameter int MemLatency    = 1,
  parameter int RespFifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tcdm_bank_adapter_if.slave   bus
);

  localparam int CntW = $clog2(RespFifoDepth + 1);
  localparam int PtrW = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
  localparam int EntW = NumInLog2 + DataWidth;

  if (MemLatency < 1) begin : g_chk_latency
    $fatal(1, "tcdm_bank_adapter: MemLatency must be >= 1");
  end
  if (RespFifoDepth < 1) begin : g_chk_depth
    $fatal(1, "tcdm_bank_adapter: RespFifoDepth must be >= 1");
  end

  // credits: reads in flight plus responses stored
  logic [CntW-1:0]      cnt_q, cnt_d;
  // read tag pipe, aligned with SRAM latency
  logic [MemLatency-1:0] tag_vld_q;
  logic [NumInLog2-1:0]  tag_ini_q [MemLatency];
  // response FIFO
  logic [EntW-1:0]      fifo_q [RespFifoDepth];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      fill_q, fill_d;

  logic                 w_ready, w_accept, w_rd_accept;
  logic                 w_push, w_pop, w_empty, w_store, w_deq;
  logic [EntW-1:0]      w_push_entry, w_head;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespFifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // request side: ready only while a response slot can still be reserved
  assign w_ready     = (cnt_q < CntW'(RespFifoDepth));
  assign w_accept    = bus.req_valid_i & w_ready;
  assign w_rd_accept = w_accept & ~bus.req_wen_i;

  assign bus.req_ready_o = w_ready;
  assign bus.mem_req_o   = w_accept;
  assign bus.mem_addr_o  = bus.req_tgt_addr_i;
  assign bus.mem_wen_o   = bus.req_wen_i;
  assign bus.mem_wdata_o = bus.req_wdata_i;
  assign bus.mem_be_o    = bus.req_be_i;

  // response side: fall-through FIFO, bypassing storage when empty
  assign w_push       = tag_vld_q[MemLatency-1];
  assign w_push_entry = {tag_ini_q[MemLatency-1], bus.mem_rdata_i};
  assign w_empty      = (fill_q == '0);
  assign w_head       = w_empty ? w_push_entry : fifo_q[rptr_q];
  assign w_pop        = bus.resp_valid_o & bus.resp_ready_i;
  assign w_store      = w_push & ~(w_empty & w_pop);
  assign w_deq        = w_pop & ~w_empty;

  assign bus.resp_valid_o = ~w_empty | w_push;
  assign {bus.resp_ini_addr_o, bus.resp_rdata_o} = w_head;

  // next-state for credit and occupancy counters
  always_comb begin
    cnt_d  = cnt_q + CntW'(w_rd_accept) - CntW'(w_pop);
    fill_d = fill_q + CntW'(w_store) - CntW'(w_deq);
  end

  // control state: counters, pointers and tag valid bits, cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      fill_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      tag_vld_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      if (w_store) wptr_q <= next_ptr(wptr_q);
      if (w_deq)   rptr_q <= next_ptr(rptr_q);
      tag_vld_q[0] <= w_rd_accept;
      for (int k = 1; k < MemLatency; k++) tag_vld_q[k] <= tag_vld_q[k-1];
    end
  end

  // datapath: tag initiator addresses and FIFO payload need no reset
  always_ff @(posedge clk_i) begin
    tag_ini_q[0] <= bus.req_ini_addr_i;
    for (int k = 1; k < MemLatency; k++) tag_ini_q[k] <= tag_ini_q[k-1];
    if (w_store) fifo_q[wptr_q] <= w_push_entry;
  end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_bank_adapter
// Description : Directed self-checking bench for tcdm_bank_adapter with a
//               1-cycle SRAM model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_bank_adapter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int IW = 5;
  localparam int EW = IW + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcdm_bank_adapter_if #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW), .NumInLog2(IW)) bus ();

  tcdm_bank_adapter #(
    .AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW), .NumInLog2(IW),
    .MemLatency(1), .RespFifoDepth(2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [EW-1:0] sb_q[$];
  logic [DW-1:0] ref_mem [4096];
  logic [DW-1:0] sram    [4096];
  logic [DW-1:0] rdata_q = '0;

  assign bus.mem_rdata_i = rdata_q;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM model: byte-masked writes, one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_req_o) begin
      if (bus.mem_wen_o) begin
        for (int b = 0; b < BW; b++)
          if (bus.mem_be_o[b]) sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        rdata_q <= sram[bus.mem_addr_o];
      end
    end
  end

  // response monitor: every handshake must match the oldest expected read
  always @(negedge clk) begin : mon
    logic [EW-1:0] exp;
    if (bus.resp_valid_o && bus.resp_ready_i) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL resp_unexpected: observed response ini %0d data 0x%0h expected none",
               bus.resp_ini_addr_o, bus.resp_rdata_o);
      end
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        check("resp_data", 64'({bus.resp_ini_addr_o, bus.resp_rdata_o}), 64'(exp));
        popped++;
      end
    end
  end

  task automatic drive_req(input logic wen, input logic [AW-1:0] addr, input logic [IW-1:0] ini,
                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    bus.req_valid_i    = 1'b1;
    bus.req_wen_i      = wen;
    bus.req_tgt_addr_i = addr;
    bus.req_ini_addr_i = ini;
    bus.req_wdata_i    = wdata;
    bus.req_be_i       = be;
  endtask

  task automatic idle_req();
    bus.req_valid_i = 1'b0;
    bus.req_wen_i   = 1'b0;
  endtask

  // bookkeeping for an accepted request: reads expect data, writes update the reference
  task automatic record_accept();
    if (bus.req_wen_i) begin
      for (int b = 0; b < BW; b++)
        if (bus.req_be_i[b]) ref_mem[bus.req_tgt_addr_i][8*b +: 8] = bus.req_wdata_i[8*b +: 8];
    end else begin
      sb_q.push_back({bus.req_ini_addr_i, ref_mem[bus.req_tgt_addr_i]});
    end
  endtask

  // request expected to be accepted in the current cycle
  task automatic accept_now(input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 64'(bus.req_ready_o), 64'd1);
    check({tag, "_mem_req"}, 64'(bus.mem_req_o), 64'd1);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'(bus.req_tgt_addr_i));
    check({tag, "_mem_wen"}, 64'(bus.mem_wen_o), 64'(bus.req_wen_i));
    check({tag, "_mem_be"}, 64'(bus.mem_be_o), 64'(bus.req_be_i));
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata_o), 64'(bus.req_wdata_i));
    record_accept();
    @(posedge clk); #1;
  endtask

  // request that may be stalled; bounded wait
  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        ok = 1'b1;
        record_accept();
      end
      @(posedge clk); #1;
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: observed no acceptance expected acceptance within 50 cycles", tag);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = init_word(i);
      sram[i]    = init_word(i);
    end
    ref_mem[12'h010] = 32'hDEAD_BEEF;
    sram[12'h010]    = 32'hDEAD_BEEF;
    idle_req();
    bus.req_tgt_addr_i = '0;
    bus.req_ini_addr_i = '0;
    bus.req_wdata_i    = '0;
    bus.req_be_i       = '0;
    bus.resp_ready_i   = 1'b1;

    // reset values
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready_o), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);

    // single read, latency one
    drive_req(1'b0, 12'h010, 5'd3, '0, 4'hF);
    accept_now("rd1");
    idle_req();
    @(negedge clk);
    check("rd1_resp_valid", 64'(bus.resp_valid_o), 64'd1);
    check("rd1_resp_ini", 64'(bus.resp_ini_addr_o), 64'd3);
    check("rd1_resp_data", 64'(bus.resp_rdata_o), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd1_after_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rd1_after_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk); #1;

    // partial write then read back
    drive_req(1'b1, 12'h020, 5'd4, 32'h1234_5678, 4'b0011);
    accept_now("wr");
    idle_req();
    @(negedge clk);
    check("wr_no_resp", 64'(bus.resp_valid_o), 64'd0);
    @(posedge clk); #1;
    drive_req(1'b0, 12'h020, 5'd4, '0, 4'hF);
    accept_now("rd_wr");
    idle_req();
    @(negedge clk);
    check("rd_wr_data", 64'(bus.resp_rdata_o), 64'hC0DE_5678);
    @(posedge clk); #1;

    // back-to-back reads with free-running response ready
    base = popped;
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b0, AW'(12'h100 + i), IW'(i), '0, 4'hF);
      accept_now("b2b");
    end
    idle_req();
    cycles(3);
    check("b2b_count", 64'(popped - base), 64'd8);

    // response back-pressure: third read stalls until credits return
    bus.resp_ready_i = 1'b0;
    drive_req(1'b0, 12'h200, 5'd7, '0, 4'hF);
    accept_now("bp_a");
    drive_req(1'b0, 12'h201, 5'd8, '0, 4'hF);
    accept_now("bp_b");
    drive_req(1'b0, 12'h202, 5'd9, '0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(bus.req_ready_o), 64'd0);
      check("bp_mem_req_low", 64'(bus.mem_req_o), 64'd0);
      check("bp_hold_valid", 64'(bus.resp_valid_o), 64'd1);
      check("bp_hold_ini", 64'(bus.resp_ini_addr_o), 64'd7);
      check("bp_hold_data", 64'(bus.resp_rdata_o), 64'(init_word(12'h200)));
      @(posedge clk); #1;
    end
    bus.resp_ready_i = 1'b1;
    wait_accept("bp_c");
    idle_req();
    cycles(4);
    check("bp_drained", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
    check("bp_ready_back", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk); #1;

    // accept and pop in the same cycle with one credit in use
    bus.resp_ready_i = 1'b0;
    drive_req(1'b0, 12'h300, 5'd10, '0, 4'hF);
    accept_now("sim_x");
    bus.resp_ready_i = 1'b1;
    drive_req(1'b0, 12'h301, 5'd11, '0, 4'hF);
    accept_now("sim_y");
    drive_req(1'b0, 12'h302, 5'd12, '0, 4'hF);
    accept_now("sim_z");
    idle_req();
    cycles(3);
    check("sim_drained", 64'(sb_q.size()), 64'd0);

    // asynchronous reset with two stored responses
    bus.resp_ready_i = 1'b0;
    drive_req(1'b0, 12'h400, 5'd13, '0, 4'hF);
    accept_now("rst_r");
    drive_req(1'b0, 12'h401, 5'd14, '0, 4'hF);
    accept_now("rst_s");
    idle_req();
    cycles(1);
    @(negedge clk);
    check("pre_rst_valid", 64'(bus.resp_valid_o), 64'd1);
    check("pre_rst_ready", 64'(bus.req_ready_o), 64'd0);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_rst_valid", 64'(bus.resp_valid_o), 64'd0);
    check("async_rst_ready", 64'(bus.req_ready_o), 64'd1);
    bus.resp_ready_i = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    @(negedge clk);
    check("post_rst_valid", 64'(bus.resp_valid_o), 64'd0);
    @(posedge clk); #1;
    drive_req(1'b0, 12'h010, 5'd1, '0, 4'hF);
    accept_now("post_rst_rd");
    idle_req();
    cycles(3);
    check("post_rst_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
